// File: rtl/riscv_run_pkg.sv
// Shared state encoding and helpers for the RISC-V run controller.
package riscv_run_pkg;

    localparam int unsigned MAX_HARTS = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    function automatic int unsigned lowest_set_idx(input logic [MAX_HARTS-1:0] vec);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_HARTS; i++) begin
            if (vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/run_prio_enc.sv
// Lowest-index priority encoder: index of the lowest set request bit plus a valid flag.
module run_prio_enc
    import riscv_run_pkg::*;
#(
    parameter int unsigned N     = 1,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [MAX_HARTS-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
    end

    assign idx_o   = IDX_W'(lowest_set_idx(req_ext));
    assign valid_o = |req_i;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: sequences per-hart core reset release, counts RUN cycles,
// collects halt/exit codes and enforces a watchdog with sticky status.
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int unsigned NUM_HARTS       = 1,
    parameter int unsigned RST_HOLD_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 20,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned CODE_W          = 32,
    parameter int unsigned HART_W          = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_HARTS-1:0]        halt_valid,
    input  logic [NUM_HARTS*CODE_W-1:0] halt_code,
    output logic [NUM_HARTS-1:0]        core_reset,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [HART_W-1:0]           fail_hart,
    output logic [CODE_W-1:0]           fail_code,
    output logic [CNT_W-1:0]            cycle_count
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    run_state_e           state_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [NUM_HARTS-1:0] halted_q;
    logic [NUM_HARTS-1:0] core_reset_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;
    logic [HART_W-1:0]    fail_hart_q;
    logic [CODE_W-1:0]    fail_code_q;
    logic [CNT_W-1:0]     cycle_q;

    logic [NUM_HARTS-1:0] new_halt_d;
    logic [NUM_HARTS-1:0] fail_mask_d;
    logic                 all_halted_d;
    logic                 wd_expired_d;
    logic                 fail_valid_d;
    logic [HART_W-1:0]    fail_hart_d;
    logic [CODE_W-1:0]    fail_code_d;
    logic [CNT_W-1:0]     cycle_inc_d;

    always_comb begin
        new_halt_d  = halt_valid & ~halted_q;
        fail_mask_d = '0;
        for (int unsigned i = 0; i < NUM_HARTS; i++) begin
            fail_mask_d[i] = new_halt_d[i] && (halt_code[i*CODE_W +: CODE_W] != '0);
        end
        all_halted_d = &(halted_q | new_halt_d);
        wd_expired_d = (TIMEOUT_CYCLES != 0) && (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cycle_inc_d  = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    end

    run_prio_enc #(
        .N     (NUM_HARTS),
        .IDX_W (HART_W)
    ) u_fail_enc (
        .req_i   (fail_mask_d),
        .idx_o   (fail_hart_d),
        .valid_o (fail_valid_d)
    );

    always_comb begin
        fail_code_d = '0;
        for (int unsigned i = 0; i < NUM_HARTS; i++) begin
            if (fail_hart_d == HART_W'(i)) fail_code_d = halt_code[i*CODE_W +: CODE_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            halted_q     <= '0;
            core_reset_q <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_hart_q  <= '0;
            fail_code_q  <= '0;
            cycle_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_HOLD;
                        hold_q      <= HOLD_W'(RST_HOLD_CYCLES - 1);
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        fail_hart_q <= '0;
                        fail_code_q <= '0;
                        cycle_q     <= '0;
                        halted_q    <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_q      <= ST_RUN;
                        core_reset_q <= '0;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    halted_q <= halted_q | new_halt_d;
                    if (fail_valid_d) begin
                        state_q      <= ST_DONE;
                        core_reset_q <= '1;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_hart_q  <= fail_hart_d;
                        fail_code_q  <= fail_code_d;
                        cycle_q      <= cycle_inc_d;
                    end else if (all_halted_d) begin
                        state_q      <= ST_DONE;
                        core_reset_q <= '1;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= 1'b1;
                        cycle_q      <= cycle_inc_d;
                    end else if (wd_expired_d) begin
                        // A timed-out run keeps the index of its last RUN cycle (TIMEOUT_CYCLES-1).
                        state_q      <= ST_DONE;
                        core_reset_q <= '1;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        timeout_q    <= 1'b1;
                    end else begin
                        core_reset_q <= core_reset_q | new_halt_d;
                        cycle_q      <= cycle_inc_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_reset  = core_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_hart   = fail_hart_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: stimulus queues expected snapshots and
// run results, a negedge monitor pops and compares them against the DUTs.
module tb_riscv_run_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_nw;
    logic [1:0]  halt_valid;
    logic [63:0] halt_code;
    logic [1:0]  core_reset;
    logic        busy, done, pass, timeout;
    logic [0:0]  fail_hart;
    logic [31:0] fail_code;
    logic [31:0] cycle_count;

    logic [1:0]  nw_halt_valid;
    logic [63:0] nw_halt_code;
    logic [1:0]  nw_core_reset;
    logic        nw_busy, nw_done, nw_pass, nw_timeout;
    logic [0:0]  nw_fail_hart;
    logic [31:0] nw_fail_code;
    logic [31:0] nw_cycle_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned run0_cyc = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [1:0]  core;
        logic        busy;
        logic        done;
        logic        chk_cnt;
        logic [31:0] cnt;
    } snap_t;

    typedef struct {
        string       name;
        logic        pass;
        logic        timeout;
        logic [0:0]  fh;
        logic [31:0] fc;
        logic [31:0] cnt;
        logic [1:0]  core;
    } res_t;

    snap_t snap_q[$];
    res_t  res_q[$];

    riscv_run_ctrl #(
        .NUM_HARTS       (2),
        .RST_HOLD_CYCLES (3),
        .TIMEOUT_CYCLES  (20),
        .CNT_W           (32),
        .CODE_W          (32)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_valid  (halt_valid),
        .halt_code   (halt_code),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_hart   (fail_hart),
        .fail_code   (fail_code),
        .cycle_count (cycle_count)
    );

    riscv_run_ctrl #(
        .NUM_HARTS       (2),
        .RST_HOLD_CYCLES (3),
        .TIMEOUT_CYCLES  (0),
        .CNT_W           (32),
        .CODE_W          (32)
    ) u_dut_nowd (
        .clk         (clk),
        .reset       (reset),
        .start       (start_nw),
        .halt_valid  (nw_halt_valid),
        .halt_code   (nw_halt_code),
        .core_reset  (nw_core_reset),
        .busy        (nw_busy),
        .done        (nw_done),
        .pass        (nw_pass),
        .timeout     (nw_timeout),
        .fail_hart   (nw_fail_hart),
        .fail_code   (nw_fail_code),
        .cycle_count (nw_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_snap(input string name, input int sel, input logic [1:0] core,
                               input logic b, input logic d, input logic chk_cnt, input logic [31:0] cnt);
        snap_t s;
        s.name = name; s.sel = sel; s.core = core; s.busy = b; s.done = d;
        s.chk_cnt = chk_cnt; s.cnt = cnt;
        snap_q.push_back(s);
    endtask

    task automatic expect_res(input string name, input logic p, input logic t, input logic [0:0] fh,
                              input logic [31:0] fc, input logic [31:0] cnt, input logic [1:0] core);
        res_t r;
        r.name = name; r.pass = p; r.timeout = t; r.fh = fh; r.fc = fc; r.cnt = cnt; r.core = core;
        res_q.push_back(r);
    endtask

    task automatic set_halt(input logic [1:0] v, input logic [31:0] c0, input logic [31:0] c1);
        halt_valid = v;
        halt_code  = {c1, c0};
    endtask

    task automatic pulse_start(input logic with_nw);
        start    = 1'b1;
        start_nw = with_nw;
        tick();
        start    = 1'b0;
        start_nw = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        for (int unsigned i = 0; i < budget && done !== 1'b1; i++) tick();
        if (done !== 1'b1) check({name, ".done_wait"}, 64'(done), 64'd1);
    endtask

    // Monitor: snapshots every negedge, run results whenever done rises.
    initial begin
        snap_t s;
        res_t  r;
        logic  done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                if (s.sel == 0) begin
                    check({s.name, ".core_reset"}, 64'(core_reset), 64'(s.core));
                    check({s.name, ".busy"}, 64'(busy), 64'(s.busy));
                    check({s.name, ".done"}, 64'(done), 64'(s.done));
                    if (s.chk_cnt) check({s.name, ".cycle_count"}, 64'(cycle_count), 64'(s.cnt));
                end else begin
                    check({s.name, ".nw_core_reset"}, 64'(nw_core_reset), 64'(s.core));
                    check({s.name, ".nw_busy"}, 64'(nw_busy), 64'(s.busy));
                    check({s.name, ".nw_done"}, 64'(nw_done), 64'(s.done));
                    if (s.chk_cnt) check({s.name, ".nw_cycle_count"}, 64'(nw_cycle_count), 64'(s.cnt));
                    check({s.name, ".nw_status"}, 64'({nw_pass, nw_timeout, nw_fail_hart, nw_fail_code}), 64'd0);
                end
            end
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    r = res_q.pop_front();
                    check({r.name, ".pass"}, 64'(pass), 64'(r.pass));
                    check({r.name, ".timeout"}, 64'(timeout), 64'(r.timeout));
                    check({r.name, ".fail_hart"}, 64'(fail_hart), 64'(r.fh));
                    check({r.name, ".fail_code"}, 64'(fail_code), 64'(r.fc));
                    check({r.name, ".cycle_count"}, 64'(cycle_count), 64'(r.cnt));
                    check({r.name, ".core_reset"}, 64'(core_reset), 64'(r.core));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000 ns, required finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start_nw = 1'b0;
        halt_valid = '0; halt_code = '0;
        nw_halt_valid = '0; nw_halt_code = '0;

        // Reset then idle
        tick();
        expect_snap("rst", 0, 2'b11, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        reset = 1'b0;
        tick(3);
        expect_snap("idle", 0, 2'b11, 1'b0, 1'b0, 1'b1, 32'd0);
        expect_snap("idle_nw", 1, 2'b11, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();

        // Normal pass, with start/halt pulses during HOLD that must be ignored
        pulse_start(1'b1);
        expect_snap("a_hold1", 0, 2'b11, 1'b1, 1'b0, 1'b1, 32'd0);
        tick(); set_halt(2'b11, 32'd0, 32'd0); start = 1'b1;
        tick(); set_halt(2'b00, 32'd0, 32'd0); start = 1'b0;
        expect_snap("a_hold3", 0, 2'b11, 1'b1, 1'b0, 1'b1, 32'd0);
        tick(); run0_cyc = cyc;
        expect_snap("a_run0", 0, 2'b00, 1'b1, 1'b0, 1'b1, 32'd0);
        tick(5); set_halt(2'b01, 32'd0, 32'd0);
        expect_snap("a_run5", 0, 2'b00, 1'b1, 1'b0, 1'b1, 32'd5);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        expect_snap("a_run6", 0, 2'b01, 1'b1, 1'b0, 1'b1, 32'd6);
        tick(); set_halt(2'b01, 32'd5, 32'd0);
        tick(); set_halt(2'b10, 32'd0, 32'd0);
        expect_snap("a_run8", 0, 2'b01, 1'b1, 1'b0, 1'b1, 32'd8);
        expect_res("a_pass", 1'b1, 1'b0, 1'b0, 32'd0, 32'd9, 2'b11);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        wait_done("a", 4);
        expect_snap("a_done", 0, 2'b11, 1'b0, 1'b1, 1'b1, 32'd9);
        tick(2); set_halt(2'b11, 32'd5, 32'd6);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        expect_snap("a_frozen", 0, 2'b11, 1'b0, 1'b1, 1'b1, 32'd9);
        tick();

        // Failure priority: both harts fail together
        pulse_start(1'b0);
        expect_snap("b_clear", 0, 2'b11, 1'b1, 1'b0, 1'b1, 32'd0);
        tick(3); tick(2);
        set_halt(2'b11, 32'd7, 32'd3);
        expect_res("b_prio", 1'b0, 1'b0, 1'b0, 32'd7, 32'd3, 2'b11);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        wait_done("b", 4);
        tick();

        // Only hart1 fails while hart0 halts cleanly in the same cycle
        pulse_start(1'b0);
        tick(3); tick(4);
        set_halt(2'b11, 32'd0, 32'd9);
        expect_res("b2_hart1", 1'b0, 1'b0, 1'b1, 32'd9, 32'd5, 2'b11);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        wait_done("b2", 4);
        tick();

        // Watchdog timeout after exactly 20 RUN cycles
        pulse_start(1'b0);
        tick(3);
        expect_res("c_timeout", 1'b0, 1'b1, 1'b0, 32'd0, 32'd19, 2'b11);
        tick(19);
        expect_snap("c_run19", 0, 2'b00, 1'b1, 1'b0, 1'b1, 32'd19);
        tick();
        expect_snap("c_done", 0, 2'b11, 1'b0, 1'b1, 1'b1, 32'd19);
        wait_done("c", 4);
        tick();

        // Last hart halts with code 0 on the timeout cycle: halt wins
        pulse_start(1'b0);
        tick(3); tick(10);
        set_halt(2'b01, 32'd0, 32'd0);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        tick(8);
        set_halt(2'b10, 32'd0, 32'd0);
        expect_res("d_collide", 1'b1, 1'b0, 1'b0, 32'd0, 32'd20, 2'b11);
        tick(); set_halt(2'b00, 32'd0, 32'd0);
        wait_done("d", 4);

        // Watchdog disabled: still running after more than 1000 cycles
        while (cyc - run0_cyc < 1010) tick();
        expect_snap("nw_busy", 1, 2'b00, 1'b1, 1'b0, 1'b1, 32'(cyc - run0_cyc));
        tick();

        // Restart from DONE clears status, then async reset mid-RUN
        pulse_start(1'b0);
        expect_snap("d_restart", 0, 2'b11, 1'b1, 1'b0, 1'b1, 32'd0);
        tick(3); tick(3);
        expect_snap("e_run3", 0, 2'b00, 1'b1, 1'b0, 1'b1, 32'd3);
        tick();
        #1 reset = 1'b1;
        expect_snap("e_async", 0, 2'b11, 1'b0, 1'b0, 1'b1, 32'd0);
        expect_snap("e_async_nw", 1, 2'b11, 1'b0, 1'b0, 1'b1, 32'd0);
        #4 reset = 1'b0;
        tick();
        expect_snap("e_idle", 0, 2'b11, 1'b0, 1'b0, 1'b1, 32'd0);
        tick(2);

        check("leftover_results", 64'(res_q.size()), 64'd0);
        check("leftover_snapshots", 64'(snap_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
